// File: rtl/bus_key_unlock.sv
// Bus-access key-sequence detector: qualified reads in a decoded window must
// present a programmed sequence of key fields before read data is enabled.
module bus_key_unlock #(
   parameter int                 ADDR_W     = 14,
   parameter logic [ADDR_W-1:0]  WIN_MASK   = 14'h3000,
   parameter logic [ADDR_W-1:0]  WIN_MATCH  = 14'h1000,
   parameter int                 KEY_W      = 4,
   parameter int                 KEY_LSB    = 4,
   parameter int                 KEY_LEN    = 6,
   parameter logic [KEY_W-1:0]   RELOCK_KEY = 4'hF,
   parameter int                 TO_W       = 8,
   localparam int                PW         = $clog2(KEY_LEN + 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       SSER,
   input  logic                       BR_W,
   input  logic [ADDR_W-1:0]          BA,
   input  logic                       bus_stb,
   input  logic [KEY_LEN*KEY_W-1:0]   key_seq,
   input  logic [TO_W-1:0]            timeout_cyc,
   input  logic                       lock,
   output logic                       unlocked,
   output logic [PW-1:0]              progress,
   output logic                       fail,
   output logic                       sdrd_oe
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MATCH,
      S_UNLOCKED
   } state_t;

   state_t            state, state_n;
   logic [PW-1:0]     progress_n;
   logic              fail_n;
   logic              unlocked_n;
   logic [TO_W-1:0]   cnt, cnt_n;

   logic              window;
   logic              qual;
   logic [KEY_W-1:0]  k;
   logic [KEY_W-1:0]  key0;
   logic [KEY_W-1:0]  exp_key;
   logic [PW-1:0]     prog_inc;
   logic [TO_W-1:0]   cnt_inc;

   assign window   = ~SSER & BR_W & ((BA & WIN_MASK) == WIN_MATCH);
   assign qual     = bus_stb & window;
   assign k        = BA[KEY_LSB +: KEY_W];
   assign key0     = key_seq[KEY_W-1:0];
   assign prog_inc = progress + PW'(1);
   assign cnt_inc  = cnt + TO_W'(1);
   assign sdrd_oe  = unlocked & window;

   // Select the key entry expected next, indexed by the current progress.
   always_comb begin
      exp_key = key0;
      for (int i = 1; i < KEY_LEN; i++) begin
         if (progress == PW'(i)) begin
            exp_key = key_seq[i*KEY_W +: KEY_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         progress <= '0;
         fail     <= 1'b0;
         unlocked <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_n;
         progress <= progress_n;
         fail     <= fail_n;
         unlocked <= unlocked_n;
         cnt      <= cnt_n;
      end
   end

   // The idle counter defaults to clear so any state change or access resets it.
   always_comb begin
      state_n    = state;
      progress_n = progress;
      fail_n     = 1'b0;
      cnt_n      = '0;
      if (lock) begin
         state_n    = S_IDLE;
         progress_n = '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (qual && (k == key0)) begin
                  state_n    = S_MATCH;
                  progress_n = PW'(1);
               end
            end
            S_MATCH: begin
               if (qual) begin
                  if (k == exp_key) begin
                     progress_n = prog_inc;
                     if (prog_inc == PW'(KEY_LEN)) begin
                        state_n = S_UNLOCKED;
                     end
                  end else begin
                     fail_n = 1'b1;
                     if (k == key0) begin
                        progress_n = PW'(1);
                     end else begin
                        state_n    = S_IDLE;
                        progress_n = '0;
                     end
                  end
               end else if ((timeout_cyc != '0) && (cnt_inc == timeout_cyc)) begin
                  state_n    = S_IDLE;
                  progress_n = '0;
                  fail_n     = 1'b1;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
            S_UNLOCKED: begin
               if (qual && (k == RELOCK_KEY)) begin
                  state_n    = S_IDLE;
                  progress_n = '0;
               end
            end
            default: begin
               state_n    = S_IDLE;
               progress_n = '0;
            end
         endcase
      end
      unlocked_n = (state_n == S_UNLOCKED);
   end

endmodule

// File: tb/tb_bus_key_unlock.sv
// Self-checking bench for bus_key_unlock: a vector table for the main flows
// plus hand-written timeout, zero-timeout and asynchronous-reset sequences.
module tb_bus_key_unlock;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         sser;
   logic         br_w;
   logic [13:0]  ba;
   logic         bus_stb;
   logic [15:0]  key_seq;
   logic [7:0]   timeout_cyc;
   logic         lock;
   logic         unlocked;
   logic [2:0]   progress;
   logic         fail;
   logic         sdrd_oe;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        sser;
      logic        br_w;
      logic [13:0] ba;
      logic        stb;
      logic        lock;
      logic        e_unl;
      logic [2:0]  e_prog;
      logic        e_fail;
      logic        e_oe;
   } vec_t;

   vec_t vecs[26];

   bus_key_unlock #(.KEY_LEN(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .SSER        (sser),
      .BR_W        (br_w),
      .BA          (ba),
      .bus_stb     (bus_stb),
      .key_seq     (key_seq),
      .timeout_cyc (timeout_cyc),
      .lock        (lock),
      .unlocked    (unlocked),
      .progress    (progress),
      .fail        (fail),
      .sdrd_oe     (sdrd_oe)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of bus inputs away from the edge, then sample just after it.
   task automatic apply_stimulus(input logic s, input logic r, input logic [13:0] a,
                                 input logic st, input logic lk);
      @(negedge clk);
      sser    = s;
      br_w    = r;
      ba      = a;
      bus_stb = st;
      lock    = lk;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      apply_stimulus(1'b1, 1'b0, 14'h0000, 1'b0, 1'b0);
   endtask

   initial begin
      int fail_seen;

      vecs[0]  = '{1'b0, 1'b1, 14'h1050, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 14'h10A0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 14'h1030, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 14'h10C0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 1'b1, 14'h1050, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 14'h1234, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 14'h1234, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 14'h10F0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 14'h3050, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 14'h1050, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 14'h1050, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 14'h10A0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 14'h1050, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 14'h10A0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 14'h1050, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 14'h10A0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 14'h1030, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 14'h10C0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};
      vecs[18] = '{1'b0, 1'b1, 14'h1050, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 14'h1050, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 1'b1, 14'h1070, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[21] = '{1'b0, 1'b1, 14'h1070, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[22] = '{1'b0, 1'b1, 14'h1050, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[23] = '{1'b0, 1'b1, 14'h1050, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
      vecs[24] = '{1'b0, 1'b1, 14'h1050, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
      vecs[25] = '{1'b0, 1'b1, 14'h1050, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};

      rst_n       = 1'b0;
      sser        = 1'b1;
      br_w        = 1'b0;
      ba          = '0;
      bus_stb     = 1'b0;
      lock        = 1'b0;
      key_seq     = 16'hC3A5;
      timeout_cyc = 8'd10;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset unlocked", {31'd0, unlocked}, 32'd0);
      check_output("reset progress", {29'd0, progress}, 32'd0);
      check_output("reset fail", {31'd0, fail}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 26; i++) begin
         apply_stimulus(vecs[i].sser, vecs[i].br_w, vecs[i].ba, vecs[i].stb, vecs[i].lock);
         check_output($sformatf("vec%0d unlocked", i), {31'd0, unlocked}, {31'd0, vecs[i].e_unl});
         check_output($sformatf("vec%0d progress", i), {29'd0, progress}, {29'd0, vecs[i].e_prog});
         check_output($sformatf("vec%0d fail", i), {31'd0, fail}, {31'd0, vecs[i].e_fail});
         check_output($sformatf("vec%0d sdrd_oe", i), {31'd0, sdrd_oe}, {31'd0, vecs[i].e_oe});
      end

      // Timeout: one key access, then the tenth idle edge must abort with a pulse.
      apply_stimulus(1'b1, 1'b0, 14'h0000, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b1, 14'h1050, 1'b1, 1'b0);
      check_output("to start progress", {29'd0, progress}, 32'd1);
      repeat (9) idle_cycle();
      check_output("to 9 progress", {29'd0, progress}, 32'd1);
      check_output("to 9 fail", {31'd0, fail}, 32'd0);
      idle_cycle();
      check_output("to 10 fail", {31'd0, fail}, 32'd1);
      check_output("to 10 progress", {29'd0, progress}, 32'd0);
      idle_cycle();
      check_output("to 11 fail", {31'd0, fail}, 32'd0);

      // Zero limit disables the timeout even after the counter wraps.
      @(negedge clk);
      timeout_cyc = 8'd0;
      apply_stimulus(1'b0, 1'b1, 14'h1050, 1'b1, 1'b0);
      fail_seen = 0;
      for (int n = 0; n < 1000; n++) begin
         idle_cycle();
         if (fail) fail_seen++;
      end
      check_output("to0 progress", {29'd0, progress}, 32'd1);
      check_output("to0 fail pulses", fail_seen, 32'd0);

      // Asynchronous reset at progress 3, between clock edges.
      apply_stimulus(1'b1, 1'b0, 14'h0000, 1'b0, 1'b1);
      apply_stimulus(1'b0, 1'b1, 14'h1050, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1, 14'h10A0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1, 14'h1030, 1'b1, 1'b0);
      check_output("pre-rst progress", {29'd0, progress}, 32'd3);
      bus_stb = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async rst progress", {29'd0, progress}, 32'd0);
      check_output("async rst unlocked", {31'd0, unlocked}, 32'd0);
      check_output("async rst fail", {31'd0, fail}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      apply_stimulus(1'b0, 1'b1, 14'h1050, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1, 14'h10A0, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1, 14'h1030, 1'b1, 1'b0);
      apply_stimulus(1'b0, 1'b1, 14'h10C0, 1'b1, 1'b0);
      check_output("post-rst unlocked", {31'd0, unlocked}, 32'd1);
      check_output("post-rst progress", {29'd0, progress}, 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
